// File: rtl/mcp_datapath.sv
// Multicycle MIPS datapath: PC, IR, data/A/B/ALUOut registers and a 32x32 register file.
// Executes one micro-step per clock under the external controller's selects and enables.
module mcp_datapath #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             mem_to_reg_i,
  input  logic             reg_dst_rtrd_i,
  input  logic             instr_or_data_i,
  input  logic             pc_branch_i,
  input  logic [1:0]       b_alu_input_i2,
  input  logic             a_alu_input_i,
  input  logic             instr_we_i,
  input  logic             pc_write_i,
  input  logic             branch_i,
  input  logic             enable_wrf_i,
  input  logic [1:0]       alu_alt_ctrl_i2,
  input  logic [WIDTH-1:0] mem_rdata_i32,
  output logic [WIDTH-1:0] mem_addr_o32,
  output logic [WIDTH-1:0] mem_wdata_o32,
  output logic [5:0]       op_o6,
  output logic             zero_o,
  output logic [WIDTH-1:0] pc_o32
);

  localparam int NREG = 32;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_ZERO
  } alu_sel_t;

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] ir_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] alu_out_reg;
  logic [WIDTH-1:0] rf_reg [NREG];

  logic [WIDTH-1:0] pc_next;
  logic             pc_load;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] imm_sh;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  alu_sel_t         alu_sel;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [NREG-1:0]  rf_we;

  assign rs_addr  = ir_reg[25:21];
  assign rt_addr  = ir_reg[20:16];
  assign rf_waddr = reg_dst_rtrd_i ? ir_reg[15:11] : rt_addr;
  assign rf_wdata = mem_to_reg_i ? data_reg : alu_out_reg;

  assign imm_ext = {{(WIDTH-16){ir_reg[15]}}, ir_reg[15:0]};
  assign imm_sh  = {imm_ext[WIDTH-3:0], 2'b00};

  assign src_a = a_alu_input_i ? a_reg : pc_reg;

  always_comb begin
    src_b = b_reg;
    case (b_alu_input_i2)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = WIDTH'(32'd4);
      2'b10:   src_b = imm_ext;
      default: src_b = imm_sh;
    endcase
  end

  // Unknown funct codes yield 0 so the controller sees zero_o = 1
  always_comb begin
    alu_sel = ALU_ADD;
    case (alu_alt_ctrl_i2)
      2'b01: alu_sel = ALU_SUB;
      2'b10: begin
        case (ir_reg[5:0])
          6'b100000: alu_sel = ALU_ADD;
          6'b100010: alu_sel = ALU_SUB;
          6'b100100: alu_sel = ALU_AND;
          6'b100101: alu_sel = ALU_OR;
          6'b101010: alu_sel = ALU_SLT;
          default:   alu_sel = ALU_ZERO;
        endcase
      end
      default: alu_sel = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_sel)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = ($signed(src_a) < $signed(src_b)) ? WIDTH'(32'd1) : '0;
      default: alu_result = '0;
    endcase
  end

  assign zero_o  = (alu_result == '0);
  assign pc_next = pc_branch_i ? alu_out_reg : alu_result;
  assign pc_load = pc_write_i | (branch_i & zero_o);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      data_reg    <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_out_reg <= '0;
    end else begin
      if (pc_load) pc_reg <= pc_next;
      if (instr_we_i) ir_reg <= mem_rdata_i32;
      data_reg    <= mem_rdata_i32;
      a_reg       <= rf_reg[rs_addr];
      b_reg       <= rf_reg[rt_addr];
      alu_out_reg <= alu_result;
    end
  end

  // Entry 0 never gets a write strobe, so it stays at its reset value of 0
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf_we
      assign rf_we[gi] = (gi != 0) && enable_wrf_i && (rf_waddr == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (rf_we[i]) rf_reg[i] <= rf_wdata;
      end
    end
  end

  assign mem_addr_o32  = instr_or_data_i ? alu_out_reg : pc_reg;
  assign mem_wdata_o32 = b_reg;
  assign op_o6         = ir_reg[31:26];
  assign pc_o32        = pc_reg;

endmodule

// File: tb/tb_mcp_datapath.sv
// Scoreboard bench for mcp_datapath: the bench plays controller and memory,
// queues expected values as it drives, and pops/compares them on observation.
module tb_mcp_datapath;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        mem_to_reg_i;
  logic        reg_dst_rtrd_i;
  logic        instr_or_data_i;
  logic        pc_branch_i;
  logic [1:0]  b_alu_input_i2;
  logic        a_alu_input_i;
  logic        instr_we_i;
  logic        pc_write_i;
  logic        branch_i;
  logic        enable_wrf_i;
  logic [1:0]  alu_alt_ctrl_i2;
  logic [31:0] mem_rdata_i32;
  logic [31:0] mem_addr_o32;
  logic [31:0] mem_wdata_o32;
  logic [5:0]  op_o6;
  logic        zero_o;
  logic [31:0] pc_o32;

  mcp_datapath #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .mem_to_reg_i    (mem_to_reg_i),
    .reg_dst_rtrd_i  (reg_dst_rtrd_i),
    .instr_or_data_i (instr_or_data_i),
    .pc_branch_i     (pc_branch_i),
    .b_alu_input_i2  (b_alu_input_i2),
    .a_alu_input_i   (a_alu_input_i),
    .instr_we_i      (instr_we_i),
    .pc_write_i      (pc_write_i),
    .branch_i        (branch_i),
    .enable_wrf_i    (enable_wrf_i),
    .alu_alt_ctrl_i2 (alu_alt_ctrl_i2),
    .mem_rdata_i32   (mem_rdata_i32),
    .mem_addr_o32    (mem_addr_o32),
    .mem_wdata_o32   (mem_wdata_o32),
    .op_o6           (op_o6),
    .zero_o          (zero_o),
    .pc_o32          (pc_o32)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Inputs change 1 time unit after the rising edge; register outputs are sampled there too
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ctl_idle();
    mem_to_reg_i    = 1'b0;
    reg_dst_rtrd_i  = 1'b0;
    instr_or_data_i = 1'b0;
    pc_branch_i     = 1'b0;
    b_alu_input_i2  = 2'b00;
    a_alu_input_i   = 1'b0;
    instr_we_i      = 1'b0;
    pc_write_i      = 1'b0;
    branch_i        = 1'b0;
    enable_wrf_i    = 1'b0;
    alu_alt_ctrl_i2 = 2'b00;
  endtask

  // Write through the data-register path: IR gives rt, memory data gives the value
  task automatic write_reg(input logic [4:0] r, input logic [31:0] val);
    ctl_idle();
    mem_rdata_i32 = itype(6'd0, 5'd0, r, 16'h0);
    instr_we_i = 1'b1;
    step();
    instr_we_i = 1'b0;
    mem_rdata_i32 = val;
    step();
    mem_to_reg_i = 1'b1;
    enable_wrf_i = 1'b1;
    step();
    ctl_idle();
  endtask

  // B loads RF[rt] every edge, so the value appears on mem_wdata two edges after the IR load
  task automatic read_reg(input logic [4:0] r, input logic [31:0] exp, input string tag);
    ctl_idle();
    mem_rdata_i32 = itype(6'd0, r, r, 16'h0);
    instr_we_i = 1'b1;
    sb_push(tag, exp);
    step();
    instr_we_i = 1'b0;
    step();
    sb_pop(mem_wdata_o32);
  endtask

  task automatic set_pc(input logic [31:0] val);
    write_reg(5'd7, val);
    mem_rdata_i32 = itype(6'd4, 5'd7, 5'd0, 16'h0);
    instr_we_i = 1'b1;
    step();
    instr_we_i = 1'b0;
    step();
    a_alu_input_i  = 1'b1;
    b_alu_input_i2 = 2'b10;
    pc_write_i     = 1'b1;
    sb_push($sformatf("set_pc_%h", val), val);
    step();
    ctl_idle();
    sb_pop(pc_o32);
  endtask

  task automatic beq_seq(input logic [4:0] rt, input logic [31:0] exp_zero,
                         input logic [31:0] exp_pc, input string tag);
    ctl_idle();
    mem_rdata_i32  = itype(6'd4, 5'd1, rt, 16'hFFFF);
    instr_we_i     = 1'b1;
    b_alu_input_i2 = 2'b01;
    pc_write_i     = 1'b1;
    step();
    ctl_idle();
    b_alu_input_i2 = 2'b11;
    step();
    ctl_idle();
    a_alu_input_i   = 1'b1;
    alu_alt_ctrl_i2 = 2'b01;
    branch_i        = 1'b1;
    pc_branch_i     = 1'b1;
    sb_push({tag, "_zero"}, exp_zero);
    sb_push({tag, "_pc"}, exp_pc);
    #1;
    sb_pop(32'(zero_o));
    step();
    ctl_idle();
    sb_pop(pc_o32);
  endtask

  logic [5:0]  rt_funct [6];
  logic [31:0] rt_exp   [6];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    rt_funct[0] = 6'b101010; rt_exp[0] = 32'h0000_0001;
    rt_funct[1] = 6'b100000; rt_exp[1] = 32'h0000_0000;
    rt_funct[2] = 6'b100010; rt_exp[2] = 32'hFFFF_FFFE;
    rt_funct[3] = 6'b100100; rt_exp[3] = 32'h0000_0001;
    rt_funct[4] = 6'b100101; rt_exp[4] = 32'hFFFF_FFFF;
    rt_funct[5] = 6'b000111; rt_exp[5] = 32'h0000_0000;

    reset_ni = 1'b0;
    ctl_idle();
    mem_rdata_i32 = 32'h0;
    #12;
    sb_push("reset_pc", 32'h0);
    sb_push("reset_op", 32'h0);
    sb_push("reset_zero", 32'h1);
    sb_push("reset_addr", 32'h0);
    sb_pop(pc_o32);
    sb_pop(32'(op_o6));
    sb_pop(32'(zero_o));
    sb_pop(mem_addr_o32);
    @(negedge clk_i);
    reset_ni = 1'b1;
    step();

    // Fetch lw $10, 4($0)
    mem_rdata_i32  = 32'h8C0A_0004;
    instr_we_i     = 1'b1;
    b_alu_input_i2 = 2'b01;
    pc_write_i     = 1'b1;
    sb_push("fetch_addr", 32'h0);
    sb_push("fetch_zero", 32'h0);
    sb_push("fetch_op", 32'h23);
    sb_push("fetch_pc", 32'h4);
    #1;
    sb_pop(mem_addr_o32);
    sb_pop(32'(zero_o));
    step();
    ctl_idle();
    sb_pop(32'(op_o6));
    sb_pop(pc_o32);

    // lw: decode, address, memory read, writeback
    step();
    a_alu_input_i  = 1'b1;
    b_alu_input_i2 = 2'b10;
    step();
    ctl_idle();
    instr_or_data_i = 1'b1;
    sb_push("lw_addr", 32'h4);
    #1;
    sb_pop(mem_addr_o32);
    mem_rdata_i32 = 32'hDEAD_BEEF;
    step();
    instr_or_data_i = 1'b0;
    mem_to_reg_i    = 1'b1;
    enable_wrf_i    = 1'b1;
    step();
    ctl_idle();
    read_reg(5'd10, 32'hDEAD_BEEF, "lw_r10");

    // R-type funct table with $1 = -1, $2 = 1, result to rd = $3
    write_reg(5'd1, 32'hFFFF_FFFF);
    write_reg(5'd2, 32'h0000_0001);
    for (int k = 0; k < 6; k++) begin
      ctl_idle();
      mem_rdata_i32 = rtype(5'd1, 5'd2, 5'd3, rt_funct[k]);
      instr_we_i = 1'b1;
      step();
      instr_we_i = 1'b0;
      step();
      a_alu_input_i   = 1'b1;
      alu_alt_ctrl_i2 = 2'b10;
      sb_push($sformatf("rtype_%b_zero", rt_funct[k]), 32'(rt_exp[k] == 32'h0));
      sb_push($sformatf("rtype_%b_aluout", rt_funct[k]), rt_exp[k]);
      #1;
      sb_pop(32'(zero_o));
      step();
      ctl_idle();
      instr_or_data_i = 1'b1;
      #1;
      sb_pop(mem_addr_o32);
      instr_or_data_i = 1'b0;
      reg_dst_rtrd_i  = 1'b1;
      enable_wrf_i    = 1'b1;
      step();
      ctl_idle();
      read_reg(5'd3, rt_exp[k], $sformatf("rtype_%b_rd", rt_funct[k]));
    end

    // beq taken (rs == rt) then not taken (rs != rt)
    set_pc(32'h0000_0100);
    beq_seq(5'd1, 32'h1, 32'h0000_0100, "beq_taken");
    beq_seq(5'd2, 32'h0, 32'h0000_0104, "beq_not_taken");

    // PC + 4 wraps to 0
    set_pc(32'hFFFF_FFFC);
    b_alu_input_i2 = 2'b01;
    pc_write_i     = 1'b1;
    sb_push("pc_wrap", 32'h0);
    step();
    ctl_idle();
    sb_pop(pc_o32);

    // $0 ignores writes
    write_reg(5'd0, 32'h0000_1234);
    read_reg(5'd0, 32'h0, "r0_write");

    // Same-edge write/read of $3: A/B capture the old value on the write edge
    write_reg(5'd3, 32'h0000_0011);
    mem_rdata_i32 = itype(6'd0, 5'd3, 5'd3, 16'h0);
    instr_we_i = 1'b1;
    step();
    instr_we_i = 1'b0;
    step();
    a_alu_input_i = 1'b1;
    step();
    enable_wrf_i = 1'b1;
    step();
    ctl_idle();
    a_alu_input_i  = 1'b1;
    b_alu_input_i2 = 2'b10;
    sb_push("fwd_b_old", 32'h0000_0011);
    sb_push("fwd_a_old", 32'h0000_0011);
    sb_push("fwd_b_new", 32'h0000_0022);
    sb_push("fwd_a_new", 32'h0000_0022);
    #1;
    sb_pop(mem_wdata_o32);
    step();
    instr_or_data_i = 1'b1;
    #1;
    sb_pop(mem_addr_o32);
    sb_pop(mem_wdata_o32);
    step();
    sb_pop(mem_addr_o32);
    ctl_idle();

    // Asynchronous reset mid-run clears PC, IR and the register file
    write_reg(5'd5, 32'h0000_0055);
    read_reg(5'd5, 32'h0000_0055, "r5_before_reset");
    set_pc(32'h0000_0040);
    sb_push("pre_reset_op", 32'h4);
    sb_pop(32'(op_o6));
    #2;
    reset_ni = 1'b0;
    sb_push("async_reset_pc", 32'h0);
    sb_push("async_reset_op", 32'h0);
    sb_push("async_reset_zero", 32'h1);
    sb_push("async_reset_addr", 32'h0);
    #1;
    sb_pop(pc_o32);
    sb_pop(32'(op_o6));
    sb_pop(32'(zero_o));
    sb_pop(mem_addr_o32);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    step();
    read_reg(5'd5, 32'h0, "r5_after_reset");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcp_datapath.md
# mcp_datapath

Multicycle MIPS datapath paired with the multicycle controller FSM. It holds the architectural and non-architectural state: PC, instruction register, data register, A/B operand registers, ALUOut and the 32×32 register file. It executes one micro-step per clock under the controller's select and enable signals. It also returns the opcode and zero flag to the controller and drives a unified instruction/data memory.

## Interface
Parameters:
- WIDTH, 32, datapath word width; instruction field positions assume 32.
- RESET_PC, 32'h0000_0000, value loaded into PC on reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_ni  in  1  reset, asynchronous, active-low.
- mem_to_reg_i  in  1  RF write data: 0 = ALUOut, 1 = data register.
- reg_dst_rtrd_i  in  1  RF write address: 0 = rt (IR[20:16]), 1 = rd (IR[15:11]).
- instr_or_data_i  in  1  memory address: 0 = PC, 1 = ALUOut.
- pc_branch_i  in  1  next-PC source: 0 = live ALU result, 1 = ALUOut.
- b_alu_input_i2  in  2  SrcB: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- a_alu_input_i  in  1  SrcA: 0 = PC, 1 = A.
- instr_we_i  in  1  IR load enable.
- pc_write_i  in  1  unconditional PC load.
- branch_i  in  1  PC load when zero flag is set.
- enable_wrf_i  in  1  RF write enable.
- alu_alt_ctrl_i2  in  2  ALUOp: 00 = add, 01 = sub, 10 = decode funct, 11 = add.
- mem_rdata_i32  in  32  memory read data; combinational w.r.t. mem_addr_o32.
- mem_addr_o32  out  32  memory address.
- mem_wdata_o32  out  32  memory write data = B register.
- op_o6  out  6  IR[31:26], to the controller.
- zero_o  out  1  live ALU result == 0.
- pc_o32  out  32  current PC (debug/trace).

## Operation
- Registers:
  - PC loads next-PC when pc_write_i | (branch_i & zero_o).
  - IR loads mem_rdata_i32 when instr_we_i.
  - The data register, A, B and ALUOut load every cycle. The data register takes mem_rdata_i32. A takes RF[rs] and B takes RF[rt]. ALUOut takes the live ALU result.
- Register file: 32 entries with 2 combinational read ports (rs = IR[25:21], rt = IR[20:16]) and 1 synchronous write port. Entry 0 reads as 0 and ignores writes.
- Funct decode (ALUOp = 10), using IR[5:0]:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt, signed two's-complement compare, result 32'd1/32'd0
  - any other funct: ALU result 0, so zero_o = 1
- Arithmetic is modulo 2^32. Overflow is ignored and no trap is raised. PC + 4 wraps from 32'hFFFF_FFFC to 0.
- Sign extension replicates IR[15] into bits 31:16. The << 2 shift drops the top two bits.
- The block contains no FSM; sequencing is owned by the controller. The memory write enable goes from the controller straight to memory and does not pass through this block.

## Timing
- Asynchronous reset: while reset_ni = 0, PC = RESET_PC and every other register and every RF entry is 0, so op_o6 = 0 and zero_o = 1 (ALU add 0+0). mem_addr_o32 = RESET_PC when instr_or_data_i = 0. Reset release takes effect at the first rising edge after deassertion.
- Reset asserted mid-instruction clears state immediately. Any in-flight RF or PC write is lost, with no partial update.
- Latency: a select change propagates combinationally to zero_o and mem_addr_o32 in the same cycle. Register outputs change one edge after their enable.
- A rising edge with enable_wrf_i set and the same register on a read port: A/B capture the pre-write value on that edge, and the new value is visible from the next cycle.
- pc_write_i and branch_i both set: PC loads once from the selected source; the two enables are ORed.
- The IR holds its value while instr_we_i = 0, so op_o6 stays stable through decode/execute.

## Test plan
- Reset: hold reset_ni = 0 mid-run with PC = 32'h40 → PC = 0, op_o6 = 0, zero_o = 1. Write $5 then assert reset → $5 reads 0.
- Fetch: mem_rdata = 32'h8C0A0004 (lw $10, 4($0)), fetch controls → IR = 32'h8C0A0004, op_o6 = 6'b100011, PC = 32'h4 after one edge.
- lw sequence: $0 + 4 → mem_addr = 32'h4; memory returns 32'hDEADBEEF → $10 = 32'hDEADBEEF after the writeback edge.
- R-type: $1 = 32'hFFFF_FFFF and $2 = 1 with funct slt → rd = 1; with funct add → rd = 0 and zero_o = 1.
- beq: taken with rs == rt and imm = 16'hFFFF → PC = PC+4−4. Not taken with rs ≠ rt → PC unchanged. PC + 4 at 32'hFFFF_FFFC → 0.
- Write to $0 with 32'h1234 → subsequent read 0. Same-edge write/read of $3 → A holds the old value for one cycle, then the new value.
